// File: rtl/io_map_decoder.sv
// io_map_decoder
//   Registered CPU chip-select decoder. A strobe cycle's address is compared
//   against NUM_REGIONS base/mask regions. The lowest matching index wins.
//   The decoder drives a one-hot, active-low chip select and inserts
//   per-region wait states before raising ready. A CPU-written bank register
//   sits at BANK_ADDR. Its bit OVL_BIT drives overlay, which gates the
//   overlay-only regions.
//
//   Optional build macro: DECODE_TIMEOUT_EN
//     When it is defined, a strobe cycle that stays in WAIT/ACTIVE/HOLD for
//     2^TMO_W-1 clocks is forced off the bus: timeout pulses, cs_n is
//     released, ready is raised, and the FSM parks in HOLD until as_n rises.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   as_n       in   CPU address strobe, active low
//   rw         in   1 = read, 0 = write
//   addr       in   CPU address [ADDR_W]
//   din        in   CPU data low bits [BANK_W]
//   cs_n       out  one-hot active-low chip selects [NUM_REGIONS]
//   ready      out  cycle may complete
//   decode_err out  one-clock pulse when no region matched
//   bank_q     out  bank register [BANK_W]
//   overlay    out  bank_q[OVL_BIT]
//   timeout    out  one-clock pulse on a timed-out cycle (0 unless enabled)
module io_map_decoder #(
    parameter int unsigned                        ADDR_W      = 16,
    parameter int unsigned                        NUM_REGIONS = 5,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]      REGION_BASE =
        {16'h8000, 16'h5F80, 16'h2000, 16'h0000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]      REGION_MASK =
        {16'h8000, 16'hFFE0, 16'hE000, 16'hE000, 16'hFC00},
    parameter int unsigned                        WAIT_W      = 3,
    parameter logic [NUM_REGIONS*WAIT_W-1:0]      REGION_WAIT =
        {3'd1, 3'd0, 3'd2, 3'd0, 3'd0},
    parameter logic [NUM_REGIONS-1:0]             OVL_ON      = 5'b00001,
    parameter logic [NUM_REGIONS-1:0]             OVL_OFF     = 5'b00000,
    parameter int unsigned                        BANK_W      = 5,
    parameter logic [ADDR_W-1:0]                  BANK_ADDR   = 16'h5F88,
    parameter int unsigned                        OVL_BIT     = 0,
    parameter int unsigned                        TMO_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   as_n,
    input  logic                   rw,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [BANK_W-1:0]      din,
    output logic [NUM_REGIONS-1:0] cs_n,
    output logic                   ready,
    output logic                   decode_err,
    output logic [BANK_W-1:0]      bank_q,
    output logic                   overlay,
    output logic                   timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]             r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_rw;
    logic [NUM_REGIONS-1:0] r_sel;
    logic                   r_hit;
    logic [WAIT_W-1:0]      r_wait;
    logic [WAIT_W-1:0]      r_cnt;
    logic [NUM_REGIONS-1:0] r_cs_n;
    logic                   r_ready;
    logic                   r_err;
    logic [BANK_W-1:0]      r_bank;
    logic                   r_timeout;

    logic [NUM_REGIONS-1:0] w_match;
    logic [NUM_REGIONS-1:0] w_onehot;
    logic                   w_hit;
    logic [WAIT_W-1:0]      w_wait;
    logic                   w_bank_wr;
    logic                   w_tmo_fire;

    // Region match against the live address. The overlay used here is the
    // registered bank bit, so a bank write only affects the next strobe.
    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            w_match[i] = ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                          REGION_BASE[i*ADDR_W +: ADDR_W])
                         && !(OVL_ON[i]  && !r_bank[OVL_BIT])
                         && !(OVL_OFF[i] &&  r_bank[OVL_BIT]);
        end
    end

    // Fixed priority: first (lowest) match wins.
    always_comb begin
        w_onehot = '0;
        w_hit    = 1'b0;
        w_wait   = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit       = 1'b1;
                w_onehot[i] = 1'b1;
                w_wait      = REGION_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign w_bank_wr = !r_rw && (r_addr == BANK_ADDR);

`ifdef DECODE_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_MAX = '1;
    logic [TMO_W-1:0] r_tmo;

    assign w_tmo_fire = (r_tmo == TMO_MAX - 1'b1);

    // The counter saturates at TMO_MAX, so a cycle parked in HOLD after a
    // timeout does not pulse again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == S_DECODE) begin
            r_tmo <= '0;
        end else if ((r_state == S_WAIT || r_state == S_ACTIVE ||
                      r_state == S_HOLD) && r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_rw      <= 1'b1;
            r_sel     <= '0;
            r_hit     <= 1'b0;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_cs_n    <= '1;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_bank    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!as_n) begin
                        r_addr  <= addr;
                        r_rw    <= rw;
                        r_sel   <= w_onehot;
                        r_hit   <= w_hit;
                        r_wait  <= w_wait;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!r_hit) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_HOLD;
                        if (w_bank_wr) r_bank <= din;
                    end else if (r_wait == '0) begin
                        r_cs_n  <= ~r_sel;
                        r_ready <= 1'b1;
                        r_state <= S_ACTIVE;
                        if (w_bank_wr) r_bank <= din;
                    end else begin
                        r_cs_n  <= ~r_sel;
                        r_ready <= 1'b0;
                        r_cnt   <= r_wait;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (as_n) begin
                        // Aborted strobe: release without ready or bank write.
                        r_cs_n  <= '1;
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_tmo_fire) begin
                        r_timeout <= 1'b1;
                        r_cs_n    <= '1;
                        r_ready   <= 1'b1;
                        r_state   <= S_HOLD;
                    end else if (r_cnt == WAIT_W'(1)) begin
                        r_ready <= 1'b1;
                        r_state <= S_ACTIVE;
                        if (w_bank_wr) r_bank <= din;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACTIVE, S_HOLD: begin
                    if (as_n) begin
                        r_cs_n  <= '1;
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_tmo_fire) begin
                        r_timeout <= 1'b1;
                        r_cs_n    <= '1;
                        r_ready   <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                default: begin
                    r_cs_n  <= '1;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cs_n       = r_cs_n;
    assign ready      = r_ready;
    assign decode_err = r_err;
    assign bank_q     = r_bank;
    assign overlay    = r_bank[OVL_BIT];
    assign timeout    = r_timeout;

endmodule

// File: doc/io_map_decoder.md
Name: io_map_decoder

Overview:
- Parametrised, registered successor to the Aliens PAL chip-select decoders.
- Decodes a CPU address-strobe cycle against NUM_REGIONS base/mask regions, with fixed priority where the lowest index wins.
- Drives one-hot active-low chip selects and inserts per-region wait states through a `ready` handshake.
- Holds a bank register written by the CPU; one of its bits gates overlay regions (work-RAM/palette switching).

Parameters:
- ADDR_W, 16, CPU address width.
- NUM_REGIONS, 5, number of decode regions.
- REGION_BASE, {16'h8000,16'h5F80,16'h2000,16'h0000,16'h0000}, packed bases; region i at [i*ADDR_W +: ADDR_W].
- REGION_MASK, {16'h8000,16'hFFE0,16'hE000,16'hE000,16'hFC00}, packed masks, same packing.
- WAIT_W, 3, wait-count width.
- REGION_WAIT, {3'd1,3'd0,3'd2,3'd0,3'd0}, packed wait states; region i at [i*WAIT_W +: WAIT_W].
- OVL_ON, 5'b00001, regions that match only when overlay=1.
- OVL_OFF, 5'b00000, regions that match only when overlay=0.
- BANK_W, 5, bank register width.
- BANK_ADDR, 16'h5F88, address of the bank register write.
- OVL_BIT, 0, index of the bank_q bit that drives overlay.
- TMO_W, 8, timeout counter width (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- as_n  in  1  CPU address strobe, active low.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  CPU address.
- din  in  BANK_W  CPU data, low bits.
- cs_n  out  NUM_REGIONS  one-hot active-low chip selects.
- ready  out  1  cycle may complete.
- decode_err  out  1  one-clock pulse when no region matched.
- bank_q  out  BANK_W  bank register.
- overlay  out  1  equals bank_q[OVL_BIT].
- timeout  out  1  one-clock pulse (optional feature only).

Behaviour:
- Reset: state IDLE, cs_n all 1, ready=0, decode_err=0, bank_q=0, overlay=0, timeout=0. Reset mid-cycle aborts immediately.
- All outputs are registered.
- Match rule: region i matches when (addr & MASK_i) == BASE_i, additionally gated by OVL_ON[i] → overlay, OVL_OFF[i] → !overlay. Setting both bits disables the region.
- Selection: the lowest matching index is selected.
- IDLE: when as_n is sampled 0, latch addr and rw, evaluate the match using the current overlay, go to DECODE. Addr/rw changes while as_n=0 are ignored.
- DECODE (latency 1 clock after the as_n=0 sample):
  - No match → decode_err=1 for 1 clock, ready=1, go HOLD.
  - Match, wait W=0 → cs_n[i]=0, ready=1, go ACTIVE.
  - Match, W>0 → cs_n[i]=0, ready=0, load counter=W, go WAIT.
- WAIT: decrement each clock; when the counter reaches 1, next state is ACTIVE with ready=1. Region with W=N therefore gives ready N clocks after cs_n asserts.
- ACTIVE/HOLD: hold outputs until as_n is sampled 1, then go IDLE. cs_n all 1 and ready=0 on the next clock.
- as_n sampled 1 during WAIT: abort to IDLE, cs_n released next clock, no ready pulse, no bank write.
- Bank write: on entry to ACTIVE or HOLD, if latched rw=0 and latched addr == BANK_ADDR, then bank_q <= din.
  - Happens once per strobe cycle; region select proceeds normally.
  - The new overlay value affects decode from the next strobe only.
- Back-to-back: as_n=0 sampled in the same clock as the return to IDLE is handled next clock (one idle clock minimum between strobes).

Optional Feature:
- Macro: DECODE_TIMEOUT_EN.
- Defined: counter clears on DECODE and counts every clock in WAIT/ACTIVE/HOLD. At 2^TMO_W-1:
  - timeout=1 for 1 clock, cs_n all 1, ready=1.
  - Go HOLD; stay until as_n=1.
- Undefined: no counter; timeout tied 0; cycles last indefinitely.

Test Plan:
- Reset, then as_n=0, addr=16'h0123, rw=1, overlay=0 → after 1 clock cs_n=5'b11101 (region1), ready=1; as_n=1 → cs_n=5'b11111, ready=0 next clock.
- Write addr=16'h5F88, din=5'h01 → cs_n=5'b10111 (region3), bank_q=5'h01, overlay=1. Next read of 16'h0123 → cs_n=5'b11110 (palette region0 wins priority).
- Read 16'h2400 (region2, W=2) → cs_n[2]=0 with ready=0 for 2 clocks, then ready=1. Read 16'h9000 (region4) → ready 1 clock after cs_n.
- Set overlay=0, read 16'h4000 → decode_err pulse 1 clock, cs_n all 1, ready=1.
- as_n rises during the region2 WAIT → cs_n released next clock, ready never asserted. rst=1 during ACTIVE → all outputs at reset values next clock, bank_q=0.
- With DECODE_TIMEOUT_EN, TMO_W=4: hold as_n=0 on 16'h0123 → timeout pulse 15 clocks after DECODE, cs_n all 1.
